// File: rtl/string_receiver.sv
// rtl/string_receiver.sv - UART line receiver with length report and expected-string match
// Define STRING_RECEIVER_PARITY_EN for 8E1 framing with a sticky parity_err output.
module string_receiver #(
   parameter int                   CLKS_PER_BIT = 868,
   parameter int                   MAX_LEN      = 16,
   parameter logic [7:0]           TERMINATOR   = 8'h0A,
   parameter int                   EXP_LEN      = 12,
   // Byte 0 sits in bits [7:0], so the literal reads reversed.
   parameter logic [8*MAX_LEN-1:0] EXPECTED     = (8*MAX_LEN)'("!dlroW olleH")
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           rx,
   input  logic [$clog2(MAX_LEN)-1:0]     rd_addr,
   output logic [7:0]                     rd_data,
   output logic                           done,
   output logic [$clog2(MAX_LEN+1)-1:0]   length,
   output logic                           match,
   output logic                           overflow,
`ifdef STRING_RECEIVER_PARITY_EN
   output logic                           parity_err,
`endif
   output logic                           frame_err
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(MAX_LEN);
   localparam int CW = $clog2(MAX_LEN+1);
   localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT/2 - 1);
   localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;

   logic          sync1_q, rxs;
   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          byte_vld_q, byte_vld_d;
   logic          frame_err_q, frame_err_d;
   logic [CW-1:0] count_q, count_d, length_q, length_d;
   logic          run_match_q, run_match_d, line_ovf_q, line_ovf_d;
   logic          done_q, done_d, match_q, match_d, overflow_q, overflow_d;
   logic          par_ok, buf_we;
   logic [AW-1:0] buf_waddr;
   logic [7:0]    exp_byte;
   logic [7:0]    buf_q [MAX_LEN];

`ifdef STRING_RECEIVER_PARITY_EN
   logic par_bad_q, par_bad_d, parity_err_q, parity_err_d;
   assign par_ok     = !par_bad_q;
   assign parity_err = parity_err_q;
`else
   assign par_ok = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      byte_vld_d  = 1'b0;
      frame_err_d = frame_err_q;
`ifdef STRING_RECEIVER_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = parity_err_q;
`endif
      case (state_q)
         S_IDLE: if (!rxs) begin
            state_d = S_START;
            timer_d = '0;
         end
         S_START: if (timer_q == T_HALF) begin
            timer_d   = '0;
            bit_idx_d = '0;
            state_d   = rxs ? S_IDLE : S_DATA;
         end else timer_d = timer_q + 1'b1;
         S_DATA: if (timer_q == T_FULL) begin
            timer_d   = '0;
            shift_d   = {rxs, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 1'b1;
`ifdef STRING_RECEIVER_PARITY_EN
            if (bit_idx_q == 3'd7) state_d = S_PARITY;
`else
            if (bit_idx_q == 3'd7) state_d = S_STOP;
`endif
         end else timer_d = timer_q + 1'b1;
`ifdef STRING_RECEIVER_PARITY_EN
         S_PARITY: if (timer_q == T_FULL) begin
            timer_d   = '0;
            par_bad_d = ^{shift_q, rxs};
            if (^{shift_q, rxs}) parity_err_d = 1'b1;
            state_d   = S_STOP;
         end else timer_d = timer_q + 1'b1;
`endif
         S_STOP: if (timer_q == T_FULL) begin
            timer_d = '0;
            if (rxs) begin
               byte_vld_d = par_ok;
               state_d    = S_IDLE;
            end else begin
               frame_err_d = 1'b1;
               state_d     = S_WAIT_HIGH;
            end
         end else timer_d = timer_q + 1'b1;
         S_WAIT_HIGH: if (rxs) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Line commit runs one cycle after the stop sample; shift_q is stable until the next DATA state.
   always_comb begin
      count_d     = count_q;
      run_match_d = run_match_q;
      line_ovf_d  = line_ovf_q;
      done_d      = 1'b0;
      length_d    = length_q;
      match_d     = match_q;
      overflow_d  = overflow_q;
      buf_we      = 1'b0;
      buf_waddr   = count_q[AW-1:0];
      exp_byte    = EXPECTED[{buf_waddr, 3'b000} +: 8];
      if (byte_vld_q) begin
         if (shift_q == TERMINATOR) begin
            done_d      = 1'b1;
            length_d    = count_q;
            overflow_d  = line_ovf_q;
            match_d     = run_match_q && (count_q == CW'(EXP_LEN)) && !line_ovf_q;
            count_d     = '0;
            run_match_d = 1'b1;
            line_ovf_d  = 1'b0;
         end else if (count_q < CW'(MAX_LEN)) begin
            buf_we  = 1'b1;
            count_d = count_q + 1'b1;
            if (count_q >= CW'(EXP_LEN) || shift_q != exp_byte) run_match_d = 1'b0;
         end else begin
            line_ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1_q     <= 1'b1;
         rxs         <= 1'b1;
         state_q     <= S_IDLE;
         timer_q     <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         byte_vld_q  <= 1'b0;
         frame_err_q <= 1'b0;
         count_q     <= '0;
         run_match_q <= 1'b1;
         line_ovf_q  <= 1'b0;
         done_q      <= 1'b0;
         length_q    <= '0;
         match_q     <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         sync1_q     <= rx;
         rxs         <= sync1_q;
         state_q     <= state_d;
         timer_q     <= timer_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         byte_vld_q  <= byte_vld_d;
         frame_err_q <= frame_err_d;
         count_q     <= count_d;
         run_match_q <= run_match_d;
         line_ovf_q  <= line_ovf_d;
         done_q      <= done_d;
         length_q    <= length_d;
         match_q     <= match_d;
         overflow_q  <= overflow_d;
      end
   end

`ifdef STRING_RECEIVER_PARITY_EN
   always_ff @(posedge clock) begin
      if (!reset) begin
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
      end
   end
`endif

   always_ff @(posedge clock) begin
      if (buf_we) buf_q[buf_waddr] <= shift_q;
   end

   assign rd_data   = buf_q[rd_addr];
   assign done      = done_q;
   assign length    = length_q;
   assign match     = match_q;
   assign overflow  = overflow_q;
   assign frame_err = frame_err_q;
endmodule

// File: doc/string_receiver.md
Name: string_receiver

Overview:
- UART 8N1 receiver that collects a line of ASCII bytes into an internal buffer until a terminator byte arrives.
- Reports the line length and whether the line matched a compile-time expected string.
- Counterpart of the board's string transmitter. Sits on the rx pin; results are read by top-level logic through a byte read port.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 4.
- MAX_LEN, 16, buffer depth in bytes (terminator not stored).
- TERMINATOR, 8'h0A, byte that ends a line.
- EXP_LEN, 12, number of bytes in EXPECTED.
- EXPECTED, "Hello World!", expected line, 8*MAX_LEN bits, byte 0 in bits [7:0].

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- rx  in  1  asynchronous UART input, idle high.
- rd_addr  in  $clog2(MAX_LEN)  buffer read address.
- rd_data  out  8  buffer byte at rd_addr, combinational read.
- done  out  1  one-cycle pulse when a line is complete.
- length  out  $clog2(MAX_LEN+1)  bytes in the last completed line; saturates at MAX_LEN.
- match  out  1  last line equalled EXPECTED exactly.
- overflow  out  1  last line exceeded MAX_LEN.
- frame_err  out  1  sticky: a stop bit was sampled low.

Behaviour:
- Reset (reset==0 at a clock edge):
  - done=0, length=0, match=0, overflow=0, frame_err=0.
  - FSM goes to IDLE; byte count=0; running-match=1.
  - Buffer contents are don't-care.
  - Reset mid-frame or mid-line abandons that frame or line.
- Input sync: rx passes through a 2-FF synchronizer; rxs denotes the synchronized value. All sampling uses rxs.
- Bit timer: counts 0..CLKS_PER_BIT-1.
- FSM states:
  - IDLE: on rxs==0 -> START, timer cleared.
  - START: at timer==CLKS_PER_BIT/2-1, if rxs==0 -> DATA with timer cleared; else -> IDLE (glitch rejected, nothing recorded).
  - DATA: at timer==CLKS_PER_BIT-1, shift in rxs, LSB first. After the 8th bit -> STOP (or PARITY when the option is enabled).
  - STOP: at timer==CLKS_PER_BIT-1:
    - rxs==1: byte valid -> IDLE.
    - rxs==0: frame_err<=1, byte discarded -> WAIT_HIGH.
  - WAIT_HIGH: -> IDLE once rxs==1. This prevents a false start on a held-low line.
- Valid byte handling, applied in the cycle after the stop sample.
  - Byte == TERMINATOR:
    - done=1 for exactly one cycle.
    - length<=count.
    - overflow<=line-overflow flag.
    - match<=running-match && count==EXP_LEN && !line-overflow.
    - Then count<=0, running-match<=1, line-overflow<=0.
    - An empty line (terminator only) gives length=0 and match=(EXP_LEN==0).
  - Other byte, count<MAX_LEN:
    - buffer[count]<=byte; count<=count+1.
    - running-match cleared if count>=EXP_LEN or byte!=EXPECTED[count].
  - Other byte, count==MAX_LEN: byte dropped, line-overflow<=1, count holds.
- Output holding: length/match/overflow change only at done. The buffer holds the last line until the next non-terminator byte overwrites it.
- Latency: done asserts 2 cycles after the terminator's stop-bit sample edge (sync + commit), measured from the sample edge.
- Back-to-back frames: a start bit immediately after the stop sample is accepted; no idle time required.

Optional Feature:
- Macro: STRING_RECEIVER_PARITY_EN.
- Defined: frame becomes 8E1.
  - A PARITY state sits between DATA and STOP and samples 1 bit at CLKS_PER_BIT-1.
  - If XOR(data, parity bit)!=0, the byte is discarded: no buffer write, no terminator detection.
  - Sticky output port parity_err (1 bit, reset 0) is set.
- Not defined: no PARITY state, no parity_err port, 8N1 only.

Test Plan (CLKS_PER_BIT=8, MAX_LEN=16, defaults otherwise):
- Send "Hello World!\n" with 1-bit gaps -> one done pulse; length=12, match=1, overflow=0; rd_addr 0..11 reads 48 65 6C 6C 6F 20 57 6F 72 6C 64 21.
- Send "Hello World?\n" then "Hi\n" -> first done: length=12, match=0. Second done: length=2, match=0, buffer[0..1]=48 69.
- Send 20 bytes 'A' then '\n' -> done: length=16, overflow=1, match=0. The next line "Hello World!\n" gives overflow=0, match=1.
- 2-cycle low glitch on rx in IDLE, then send "\n" -> no byte recorded from the glitch; done with length=0, frame_err=0.
- Frame with stop bit forced low, then "Hello World!\n" -> frame_err=1 and stays 1; bad byte absent from buffer; match=1.
- Assert reset (0) for one cycle mid-byte of "Hel", then send "Hello World!\n" -> outputs 0 after reset; then done with length=12, match=1.
